// File: rtl/instruction_fetch_pipe.sv
// instruction_fetch_pipe: MIPS fetch stage with PC register, loadable on-chip
// instruction memory and the IF/ID pipeline register.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   stall, flush          hazard-unit hold / bubble controls
//   PCSrc, pc_branch      branch redirect request and target
//   jump, pc_jump         jump redirect request and target (beats PCSrc)
//   imem_we/waddr/wdata   synchronous instruction memory write port
//   pc_wire               current PC
//   instruction, pc_incrementado, if_valid   IF/ID register contents
//   misalign_err          sticky flag: a redirect target was not word aligned
//   fetch_count           saturating count of valid IF/ID loads
module instruction_fetch_pipe #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          PCSrc,
  input  logic [ADDR_W-1:0]             pc_branch,
  input  logic                          jump,
  input  logic [ADDR_W-1:0]             pc_jump,
  input  logic                          imem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0]            imem_wdata,
  output logic [ADDR_W-1:0]             pc_wire,
  output logic [INSTR_W-1:0]            instruction,
  output logic [ADDR_W-1:0]             pc_incrementado,
  output logic                          if_valid,
  output logic                          misalign_err,
  output logic [CNT_W-1:0]              fetch_count
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  logic [INSTR_W-1:0] mem [MEM_DEPTH];
  logic [IDX_W-1:0]   rd_idx;
  logic [INSTR_W-1:0] rd_word;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  pc_next;
  logic               redirect_misaligned;
  logic               ifid_load;

  // Word index ignores upper PC bits, so fetch addresses wrap over the memory.
  assign rd_idx   = pc_wire[IDX_W+1:2];
  assign rd_word  = mem[rd_idx];
  assign pc_plus4 = pc_wire + ADDR_W'(4);
  assign ifid_load = !flush && !stall;

  // Next-PC selection; a redirect wins over stall, targets are word-aligned.
  always_comb begin
    pc_next             = pc_plus4;
    redirect_misaligned = 1'b0;
    if (jump) begin
      pc_next             = {pc_jump[ADDR_W-1:2], 2'b00};
      redirect_misaligned = |pc_jump[1:0];
    end else if (PCSrc) begin
      pc_next             = {pc_branch[ADDR_W-1:2], 2'b00};
      redirect_misaligned = |pc_branch[1:0];
    end else if (stall) begin
      pc_next = pc_wire;
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  // PC register and sticky misalignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_wire      <= ADDR_W'(RESET_PC);
      misalign_err <= 1'b0;
    end else begin
      pc_wire <= pc_next;
      if (redirect_misaligned) begin
        misalign_err <= 1'b1;
      end
    end
  end

  // IF/ID register: flush inserts a NOP bubble, stall holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction     <= '0;
      pc_incrementado <= '0;
      if_valid        <= 1'b0;
    end else if (flush) begin
      instruction     <= '0;
      pc_incrementado <= '0;
      if_valid        <= 1'b0;
    end else if (!stall) begin
      instruction     <= rd_word;
      pc_incrementado <= pc_plus4;
      if_valid        <= 1'b1;
    end
  end

  // Saturating count of valid instructions entering IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (ifid_load && (fetch_count != {CNT_W{1'b1}})) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule
